// File: rtl/aes_round_key_mem_if.sv
// Bus between the AES round-key memory, its cipher block and the shared S-box.
// master = cipher block / S-box side, slave = round-key memory.
interface aes_round_key_mem_if;
   logic         init;
   logic         keylen;
   logic [255:0] key;
   logic [3:0]   round;
   logic [127:0] round_key;
   logic         ready;
   logic [31:0]  sboxw;
   logic [31:0]  new_sboxw;

   modport master (
      output init, keylen, key, round, new_sboxw,
      input  round_key, ready, sboxw
   );

   modport slave (
      input  init, keylen, key, round, new_sboxw,
      output round_key, ready, sboxw
   );
endinterface

// File: rtl/aes_round_key_mem.sv
// AES-128/256 key expansion into a 15-entry round-key memory, one round key per
// cycle, using an external shared S-box; round keys are read combinationally.
//
// state | meaning
// IDLE  | schedule valid (or empty after reset), waiting for init
// GEN   | writing key_mem[ctr] each cycle until ctr == NR
module aes_round_key_mem #(
   parameter int NUM_KEYS = 15
) (
   input logic                clk,
   input logic                reset,
   aes_round_key_mem_if.slave rk
);

   typedef enum logic {IDLE, GEN} state_e;

   state_e       state_q, state_d;
   logic [3:0]   ctr_q;
   logic [7:0]   rcon_q;
   logic         keylen_q;
   logic [255:0] key_q;
   logic [127:0] prev_q, prev2_q;
   logic [127:0] key_mem_q [NUM_KEYS];

   logic [3:0]   nr;
   logic         accept;
   logic         gen_we;
   logic         last;
   logic         odd_step;
   logic         rcon_step;
   logic [127:0] base;
   logic [31:0]  t;
   logic [31:0]  w0, w1, w2, w3;
   logic [127:0] new_key;

   assign nr       = keylen_q ? 4'd14 : 4'd10;
   assign last     = (ctr_q == nr);
   assign odd_step = keylen_q & ctr_q[0];

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // FSM next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (rk.init) state_d = GEN;
         GEN:     if (last)    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      rk.ready = 1'b0;
      rk.sboxw = 32'h0;
      accept   = 1'b0;
      gen_we   = 1'b0;
      case (state_q)
         IDLE: begin
            rk.ready = 1'b1;
            accept   = rk.init;
         end
         GEN: begin
            rk.sboxw = prev_q[31:0];
            gen_we   = 1'b1;
         end
         default: ;
      endcase
   end

   // Odd AES-256 steps use SubWord only; all other steps use rotate plus rcon.
   always_comb begin
      base      = keylen_q ? prev2_q : prev_q;
      t         = odd_step ? rk.new_sboxw
                           : ({rk.new_sboxw[23:0], rk.new_sboxw[31:24]} ^ {rcon_q, 24'h0});
      w0        = base[127:96] ^ t;
      w1        = base[95:64]  ^ w0;
      w2        = base[63:32]  ^ w1;
      w3        = base[31:0]   ^ w2;
      new_key   = {w0, w1, w2, w3};
      rcon_step = 1'b1;
      if (ctr_q == 4'd0) begin
         new_key   = key_q[255:128];
         rcon_step = 1'b0;
      end else if (keylen_q && ctr_q == 4'd1) begin
         new_key   = key_q[127:0];
         rcon_step = 1'b0;
      end else if (odd_step) begin
         rcon_step = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ctr_q    <= 4'd0;
         rcon_q   <= 8'h01;
         keylen_q <= 1'b0;
         key_q    <= 256'h0;
         prev_q   <= 128'h0;
         prev2_q  <= 128'h0;
         for (int i = 0; i < NUM_KEYS; i++) key_mem_q[i] <= 128'h0;
      end else if (accept) begin
         ctr_q    <= 4'd0;
         rcon_q   <= 8'h01;
         keylen_q <= rk.keylen;
         key_q    <= rk.key;
      end else if (gen_we) begin
         key_mem_q[ctr_q] <= new_key;
         prev_q           <= new_key;
         prev2_q          <= prev_q;
         ctr_q            <= ctr_q + 4'd1;
         if (rcon_step)
            rcon_q <= {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
      end
   end

   assign rk.round_key = (rk.round < 4'(NUM_KEYS)) ? key_mem_q[rk.round] : 128'h0;

endmodule

// File: tb/tb_aes_round_key_mem.sv
// Directed bench for aes_round_key_mem with a behavioural S-box on the shared port.
module tb_aes_round_key_mem;

   logic clk = 1'b0;
   logic reset;
   int   n_cmp = 0;
   int   n_err = 0;
   int   low;

   logic [7:0] sbox_tab [256];

   aes_round_key_mem_if rk_if ();

   aes_round_key_mem #(.NUM_KEYS(15)) dut (
      .clk   (clk),
      .reset (reset),
      .rk    (rk_if.slave)
   );

   always #5 clk = ~clk;

   localparam logic [255:0] KEY128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
   localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h0;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
      logic [7:0] r = v;
      for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
      return r;
   endfunction

   function automatic logic [7:0] sbox_calc(input logic [7:0] a);
      logic [7:0] inv = 8'h0;
      for (int i = 1; i < 256; i++)
         if (gmul(a, 8'(i)) == 8'h01) inv = 8'(i);
      return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
   endfunction

   assign rk_if.new_sboxw = {sbox_tab[rk_if.sboxw[31:24]], sbox_tab[rk_if.sboxw[23:16]],
                             sbox_tab[rk_if.sboxw[15:8]],  sbox_tab[rk_if.sboxw[7:0]]};

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic read_key(input string tag, input int idx, input logic [127:0] exp);
      rk_if.round = 4'(idx);
      #1;
      check(tag, rk_if.round_key, exp);
   endtask

   // Pulses init, then counts ready-low cycles; optionally re-pulses init or
   // asserts reset at a given low cycle.
   task automatic run_expand(input logic kl, input logic [255:0] k,
                             input int glitch_at, input int reset_at, output int n_low);
      @(negedge clk);
      rk_if.key    = k;
      rk_if.keylen = kl;
      rk_if.init   = 1'b1;
      @(negedge clk);
      rk_if.init = 1'b0;
      n_low = 0;
      while (!rk_if.ready && n_low < 100) begin
         n_low++;
         if (n_low == glitch_at) begin
            rk_if.init   = 1'b1;
            rk_if.key    = ~k;
            rk_if.keylen = ~kl;
         end else begin
            rk_if.init = 1'b0;
         end
         reset = (n_low == reset_at);
         @(negedge clk);
      end
      rk_if.init = 1'b0;
      reset      = 1'b0;
      check("expand_terminates", 128'(n_low < 100), 128'(1));
   endtask

   initial begin
      for (int i = 0; i < 256; i++) sbox_tab[i] = sbox_calc(8'(i));
      reset        = 1'b1;
      rk_if.init   = 1'b0;
      rk_if.keylen = 1'b0;
      rk_if.key    = 256'h0;
      rk_if.round  = 4'd0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      check("reset_ready", 128'(rk_if.ready), 128'(1));
      check("reset_sboxw", 128'(rk_if.sboxw), 128'h0);
      read_key("reset_rk0", 0, 128'h0);
      read_key("reset_rk14", 14, 128'h0);

      // AES-128
      run_expand(1'b0, KEY128, 0, 0, low);
      check("aes128_low_cycles", 128'(low), 128'(11));
      check("idle_sboxw_128", 128'(rk_if.sboxw), 128'h0);
      read_key("aes128_k0", 0, 128'h000102030405060708090a0b0c0d0e0f);
      read_key("aes128_k1", 1, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
      read_key("aes128_k10", 10, 128'h13111d7fe3944a17f307a78b4d2b30c5);
      read_key("aes128_k11_untouched", 11, 128'h0);
      read_key("round15_zero", 15, 128'h0);

      // AES-256
      run_expand(1'b1, KEY256, 0, 0, low);
      check("aes256_low_cycles", 128'(low), 128'(15));
      check("idle_sboxw_256", 128'(rk_if.sboxw), 128'h0);
      read_key("aes256_k0", 0, 128'h000102030405060708090a0b0c0d0e0f);
      read_key("aes256_k1", 1, 128'h101112131415161718191a1b1c1d1e1f);
      read_key("aes256_k2", 2, 128'ha573c29fa176c498a97fce93a572c09c);
      read_key("aes256_k14", 14, 128'h24fc79ccbf0979e9371ac23c6d68de36);
      read_key("aes256_round15", 15, 128'h0);

      // AES-128 with a second init during cycle 5; entries 11..14 keep AES-256 data
      run_expand(1'b0, KEY128, 5, 0, low);
      check("ignored_init_low_cycles", 128'(low), 128'(11));
      read_key("ignored_init_k10", 10, 128'h13111d7fe3944a17f307a78b4d2b30c5);
      read_key("ignored_init_k1", 1, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
      read_key("stale_k14", 14, 128'h24fc79ccbf0979e9371ac23c6d68de36);

      // AES-256 aborted by reset at cycle 7
      run_expand(1'b1, KEY256, 0, 7, low);
      check("reset_abort_low_cycles", 128'(low), 128'(7));
      check("reset_abort_ready", 128'(rk_if.ready), 128'(1));
      check("reset_abort_sboxw", 128'(rk_if.sboxw), 128'h0);
      for (int r = 0; r < 16; r++) read_key($sformatf("reset_abort_rk%0d", r), r, 128'h0);

      run_expand(1'b1, KEY256, 0, 0, low);
      check("restart_low_cycles", 128'(low), 128'(15));
      read_key("restart_k14", 14, 128'h24fc79ccbf0979e9371ac23c6d68de36);
      read_key("restart_k2", 2, 128'ha573c29fa176c498a97fce93a572c09c);

      // ready stays high while idle with no init
      repeat (3) @(negedge clk);
      check("idle_ready_hold", 128'(rk_if.ready), 128'(1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
